// File: rtl/csr_commit_gate_pkg.sv
// Shared types for the CSR commit gate: ROB tag type, queue entry layout and entry state.
package csr_commit_gate_pkg;

    localparam int NUM_OF_GRADUATE = 2;
    localparam int ROB_TAG_W       = 6;
    localparam int CSR_PAYLOAD_W   = 64;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic                     valid;
        logic                     armed;
        rob_tag_t                 tag;
        logic [CSR_PAYLOAD_W-1:0] payload;
    } csr_gate_entry_t;

    typedef enum logic [1:0] {
        ENT_EMPTY   = 2'd0,
        ENT_PENDING = 2'd1,
        ENT_ARMED   = 2'd3
    } csr_gate_state_e;

    // An armed bit is only meaningful on a valid entry.
    function automatic csr_gate_state_e entry_state(input logic valid, input logic armed);
        if (!valid) begin
            return ENT_EMPTY;
        end else if (armed) begin
            return ENT_ARMED;
        end
        return ENT_PENDING;
    endfunction

endpackage

// File: rtl/csr_commit_match.sv
// Compares one queue entry's ROB tag against every commit lane; one hit bit per lane.
module csr_commit_match
    import csr_commit_gate_pkg::*;
#(
    parameter int NUM_GRAD = NUM_OF_GRADUATE,
    parameter int TAG_W    = ROB_TAG_W
)(
    input  logic [TAG_W-1:0]          i_entry_tag,
    input  logic                      i_entry_pending,
    input  logic [NUM_GRAD-1:0]       i_commit_valid,
    input  logic [NUM_GRAD-1:0]       i_commit_is_csr,
    input  logic [NUM_GRAD*TAG_W-1:0] i_commit_tag,
    output logic [NUM_GRAD-1:0]       o_lane_hit
);

    always_comb begin
        o_lane_hit = '0;
        for (int l = 0; l < NUM_GRAD; l++) begin
            o_lane_hit[l] = i_entry_pending && i_commit_valid[l] && i_commit_is_csr[l] &&
                            (i_commit_tag[l*TAG_W +: TAG_W] == i_entry_tag);
        end
    end

endmodule

// File: rtl/csr_commit_gate.sv
// In-order holding queue between renamer dispatch and the CSRU: an op is released only once
// its ROB tag has graduated; a flush discards every op that has not yet graduated.
module csr_commit_gate
    import csr_commit_gate_pkg::*;
#(
    parameter int NUM_GRAD  = NUM_OF_GRADUATE,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = ROB_TAG_W,
    parameter int PAYLOAD_W = CSR_PAYLOAD_W
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [NUM_GRAD-1:0]       commit_valid,
    input  logic [NUM_GRAD-1:0]       commit_is_csr,
    input  logic [NUM_GRAD*TAG_W-1:0] commit_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [TAG_W-1:0]          out_tag,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_armed;
    logic [TAG_W-1:0]     r_tag     [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];

    logic [IDX_W-1:0]     w_head_idx;
    logic [IDX_W-1:0]     w_tail_idx;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DEPTH-1:0]     w_hit;
    logic [DEPTH-1:0]     w_armed_nxt;
    logic [DEPTH-1:0]     w_keep;
    logic [PTR_W-1:0]     w_arm_cnt;
    logic [NUM_GRAD-1:0]  w_lane_hit [DEPTH];
    logic [NUM_GRAD-1:0]  w_lane_any;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign count      = r_tail - r_head;
    assign w_full     = (count == PTR_W'(DEPTH));
    assign w_empty    = (count == '0);

    // Full stays full for a cycle even if the head pops: no enqueue bypass.
    assign in_ready   = !w_full && !flush;
    assign w_push     = in_valid && in_ready;

    assign out_valid   = !w_empty &&
                         (entry_state(r_valid[w_head_idx], r_armed[w_head_idx]) == ENT_ARMED);
    assign w_pop       = out_valid && out_ready;
    assign out_tag     = out_valid ? r_tag[w_head_idx]     : '0;
    assign out_payload = out_valid ? r_payload[w_head_idx] : '0;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        csr_commit_match #(
            .NUM_GRAD (NUM_GRAD),
            .TAG_W    (TAG_W)
        ) u_match (
            .i_entry_tag     (r_tag[gi]),
            .i_entry_pending (entry_state(r_valid[gi], r_armed[gi]) == ENT_PENDING),
            .i_commit_valid  (commit_valid),
            .i_commit_is_csr (commit_is_csr),
            .i_commit_tag    (commit_tag),
            .o_lane_hit      (w_lane_hit[gi])
        );
        assign w_hit[gi]       = |w_lane_hit[gi];
        assign w_armed_nxt[gi] = r_valid[gi] && (r_armed[gi] || w_hit[gi]);
    end

    // Length of the armed run starting at head, including this cycle's matches; a flush keeps it.
    always_comb begin
        logic             run;
        logic [IDX_W-1:0] idx;
        run       = 1'b1;
        idx       = '0;
        w_arm_cnt = '0;
        w_keep    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_head_idx + IDX_W'(k);
            if (run && (PTR_W'(k) < count) && w_armed_nxt[idx]) begin
                w_arm_cnt   = w_arm_cnt + PTR_W'(1);
                w_keep[idx] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_armed <= '0;
        end else begin
            r_armed <= r_armed | w_hit;
            if (flush) begin
                r_valid <= r_valid & w_keep;
                r_armed <= (r_armed | w_hit) & w_keep;
                r_tail  <= r_head + w_arm_cnt;
            end else if (w_push) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_armed[w_tail_idx] <= 1'b0;
                r_tail              <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[w_head_idx] <= 1'b0;
                r_armed[w_head_idx] <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[w_tail_idx]     <= in_tag;
            r_payload[w_tail_idx] <= in_payload;
        end
    end

    always_comb begin
        w_lane_any = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_lane_any = w_lane_any | w_lane_hit[e];
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && in_ready && w_full));
    a_no_pop_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && !out_valid));
    for (genvar gl = 0; gl < NUM_GRAD; gl++) begin : g_lane_chk
        a_commit_hits: assert property (@(posedge clk) disable iff (!rst_n)
            (commit_valid[gl] && commit_is_csr[gl]) |-> w_lane_any[gl]);
    end

endmodule

// File: tb/tb_csr_commit_gate.sv
// Randomized plus directed bench for csr_commit_gate with a queue-based reference model and
// a scoreboard monitor that checks every op accepted by the CSRU.
module tb_csr_commit_gate;

    localparam int DEPTH = 4;
    localparam int NG    = 2;
    localparam int TW    = 6;
    localparam int PW    = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_tag;
    logic [PW-1:0] in_payload;
    logic [NG-1:0] commit_valid;
    logic [NG-1:0] commit_is_csr;
    logic [NG*TW-1:0] commit_tag;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [TW-1:0] out_tag;
    logic [2:0]    count;

    csr_commit_gate #(.NUM_GRAD(NG), .DEPTH(DEPTH), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_payload(in_payload),
        .commit_valid(commit_valid), .commit_is_csr(commit_is_csr), .commit_tag(commit_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_tag(out_tag), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [PW-1:0] pl;
        bit            armed;
        bit            queued;
    } ent_t;
    typedef struct {
        logic [TW-1:0] tag;
        logic [PW-1:0] pl;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    bit            pend_push, pend_pop, pend_flush;
    logic [TW-1:0] pend_tag;
    logic [PW-1:0] pend_pl;
    logic [NG-1:0] pend_cv, pend_csr;
    logic [TW-1:0] pend_ct [NG];
    logic [TW-1:0] next_tag = 6'd20;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted op must be the oldest graduated op not yet consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {58'd0, out_tag}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_tag", {58'd0, out_tag}, {58'd0, e.tag});
                chk("issue_payload", out_payload, e.pl);
            end
        end
    end

    // Advance the model across one clock edge using the inputs applied before it.
    task automatic tick();
        ent_t kept[$];
        @(posedge clk);
        #1;
        for (int l = 0; l < NG; l++) begin
            if (pend_cv[l] && pend_csr[l]) begin
                foreach (mq[i]) begin
                    if (!mq[i].armed && mq[i].tag == pend_ct[l]) mq[i].armed = 1'b1;
                end
            end
        end
        foreach (mq[i]) begin
            if (mq[i].armed && !mq[i].queued) begin
                exp_q.push_back('{tag: mq[i].tag, pl: mq[i].pl});
                mq[i].queued = 1'b1;
            end
        end
        if (pend_pop) void'(mq.pop_front());
        if (pend_flush) begin
            foreach (mq[i]) if (mq[i].armed) kept.push_back(mq[i]);
            mq = kept;
        end
        if (pend_push) mq.push_back('{tag: pend_tag, pl: pend_pl, armed: 1'b0, queued: 1'b0});
    endtask

    task automatic drive(input logic iv, input logic [TW-1:0] itag, input logic [PW-1:0] ipl,
                         input logic [NG-1:0] cv, input logic [NG-1:0] ccsr,
                         input logic [TW-1:0] ct0, input logic [TW-1:0] ct1,
                         input logic fl, input logic ordy);
        bit exp_ir, exp_ov;
        in_valid      = iv;
        in_tag        = itag;
        in_payload    = ipl;
        commit_valid  = cv;
        commit_is_csr = ccsr;
        commit_tag    = {ct1, ct0};
        flush         = fl;
        out_ready     = ordy;
        #1;
        exp_ir = !fl && (mq.size() < DEPTH);
        exp_ov = (mq.size() > 0) && mq[0].armed;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        chk("count", {61'd0, count}, 64'(mq.size()));
        if (exp_ov) chk("head_tag", {58'd0, out_tag}, {58'd0, mq[0].tag});
        else        chk("idle_tag_gated", {58'd0, out_tag}, 64'd0);
        pend_push  = iv && exp_ir;
        pend_pop   = exp_ov && ordy;
        pend_flush = fl;
        pend_tag   = itag;
        pend_pl    = ipl;
        pend_cv    = cv;
        pend_csr   = ccsr;
        pend_ct[0] = ct0;
        pend_ct[1] = ct1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, ordy);
    endtask

    task automatic enq(input logic [TW-1:0] t);
        drive(1'b1, t, {$urandom, $urandom}, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [TW-1:0] fresh_tag();
        bit clash;
        do begin
            next_tag++;
            clash = 1'b0;
            foreach (mq[i]) if (mq[i].tag == next_tag) clash = 1'b1;
        end while (clash);
        return next_tag;
    endfunction

    // Commit the oldest not-yet-graduated ops in order, filling other lanes with non-CSR commits.
    task automatic rand_cycle(input int flush_pct, input bit allow_enq, input bit force_ordy);
        logic [TW-1:0] pt[$];
        logic [NG-1:0] cv, csr;
        logic [TW-1:0] ct0, ct1;
        int n, lane;
        foreach (mq[i]) if (!mq[i].armed) pt.push_back(mq[i].tag);
        n   = $urandom_range(0, (pt.size() < 2) ? pt.size() : 2);
        cv  = NG'($urandom);
        csr = '0;
        ct0 = TW'($urandom);
        ct1 = TW'($urandom);
        if (n == 2) begin
            cv = 2'b11; csr = 2'b11; ct0 = pt[0]; ct1 = pt[1];
        end else if (n == 1) begin
            lane = $urandom_range(0, 1);
            cv[lane] = 1'b1; csr[lane] = 1'b1;
            if (lane == 0) ct0 = pt[0]; else ct1 = pt[0];
        end
        drive(allow_enq && ($urandom_range(0, 9) < 7), fresh_tag(), {$urandom, $urandom},
              cv, csr, ct0, ct1, $urandom_range(0, 99) < flush_pct,
              force_ordy ? 1'b1 : 1'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {pend_push, pend_pop, pend_flush} = '0;
        pend_cv = '0; pend_csr = '0;
        in_valid = 1'b0; in_tag = '0; in_payload = '0; flush = 1'b0;
        commit_valid = '0; commit_is_csr = '0; commit_tag = '0; out_ready = 1'b0;
        #3;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_count", {61'd0, count}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: dispatch tag 5, graduate on lane 1, issue next cycle.
        tick(); enq(6'd5);
        tick(); drive(1'b0, '0, '0, 2'b10, 2'b10, 6'd0, 6'd5, 1'b0, 1'b0);
        tick(); idle(1'b1);
        tick(); idle(1'b0);

        // Fill, reject when full, two graduations in one cycle, back-to-back issue.
        for (int t = 1; t <= DEPTH; t++) begin tick(); enq(TW'(t)); end
        tick(); enq(6'd9);
        tick(); drive(1'b0, '0, '0, 2'b11, 2'b11, 6'd1, 6'd2, 1'b0, 1'b0);
        tick(); idle(1'b1);
        tick(); drive(1'b0, '0, '0, 2'b11, 2'b11, 6'd3, 6'd4, 1'b0, 1'b1);
        tick(); idle(1'b1);
        tick(); idle(1'b1);
        tick(); idle(1'b0);

        // Graduation and flush together: 7 survives, 8 and 9 and the offered 10 are dropped.
        tick(); enq(6'd7);
        tick(); enq(6'd8);
        tick(); enq(6'd9);
        tick(); drive(1'b1, 6'd10, 64'hA5A5, 2'b01, 2'b01, 6'd7, 6'd0, 1'b1, 1'b0);
        tick(); idle(1'b1);
        tick(); idle(1'b0);

        // Flush on a nearly full queue blocks the offered op and clears all pending ones.
        tick(); enq(6'd11);
        tick(); enq(6'd12);
        tick(); enq(6'd13);
        tick(); drive(1'b1, 6'd14, 64'h1414, '0, '0, '0, '0, 1'b1, 1'b0);
        tick(); idle(1'b0);

        for (int c = 0; c < 400; c++) begin tick(); rand_cycle(5, 1'b1, 1'b0); end

        // Asynchronous reset in the middle of traffic.
        tick();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; commit_valid = '0; commit_is_csr = '0; out_ready = 1'b0;
        #1;
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_count", {61'd0, count}, 64'd0);
        chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        mq.delete();
        exp_q.delete();
        {pend_push, pend_pop, pend_flush} = '0;
        pend_cv = '0; pend_csr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 200; c++) begin tick(); rand_cycle(3, 1'b1, 1'b0); end

        for (int c = 0; c < 40; c++) begin tick(); rand_cycle(0, 1'b0, 1'b1); end
        tick(); idle(1'b0);
        chk("drain_count", {61'd0, count}, 64'd0);
        chk("drain_scoreboard_left", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
